// File: rtl/abro_pkg.sv
// rtl/abro_pkg.sv - shared state type and mask helper for the N-input ABRO controller
package abro_pkg;

    typedef enum logic [1:0] {
        WAIT = 2'd0,
        EMIT = 2'd1,
        HOLD = 2'd2
    } abro_state_t;

    function automatic logic [31:0] all_ones_mask(input int n);
        return (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    endfunction

endpackage

// File: rtl/abro_sat_counter.sv
// rtl/abro_sat_counter.sv - saturating up-counter with synchronous clear and increment enable
module abro_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/abro_n_fsm.sv
// rtl/abro_n_fsm.sv - N-input ABRO controller; optional collection timeout under ABRO_TIMEOUT_EN
module abro_n_fsm
    import abro_pkg::*;
#(
    parameter int N_IN           = 2,
    parameter int OUT_LEVEL      = 0,
    parameter int CNT_W          = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             r_restart,
    input  logic [N_IN-1:0]  in_vec,
    output logic             O,
    output logic [N_IN-1:0]  seen,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] fire_cnt,
    output logic             timeout
);

    if (N_IN < 1 || N_IN > 32 || CNT_W < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("abro_n_fsm: parameter out of range");
    end

    localparam logic [N_IN-1:0] FULL_MASK = N_IN'(all_ones_mask(N_IN));
    localparam logic            LEVEL     = (OUT_LEVEL != 0);

    abro_state_t     state_q;
    logic [N_IN-1:0] merged;
    logic            complete;
    logic            abandon;

    assign merged   = seen | in_vec;
    // restart outranks completion, so a restart cycle never fires
    assign complete = (state_q == WAIT) && !r_restart && (merged == FULL_MASK);
    assign state    = state_q;

    abro_sat_counter #(.W(CNT_W)) u_fire_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .inc   (complete),
        .count (fire_cnt)
    );

`ifdef ABRO_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt;
    logic            to_clr;
    logic            timeout_q;

    assign abandon = (state_q == WAIT) && !r_restart && !complete &&
                     (to_cnt == TO_W'(TIMEOUT_CYCLES));
    assign to_clr  = r_restart || abandon || complete ||
                     (state_q != WAIT) || (seen == '0);
    assign timeout = timeout_q;

    abro_sat_counter #(.W(TO_W)) u_to_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (to_clr),
        .inc   (1'b1),
        .count (to_cnt)
    );
`else
    assign abandon = 1'b0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= WAIT;
            seen      <= '0;
            O         <= 1'b0;
`ifdef ABRO_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
        end else begin
`ifdef ABRO_TIMEOUT_EN
            timeout_q <= abandon;
`endif
            if (r_restart) begin
                state_q <= WAIT;
                seen    <= '0;
                O       <= 1'b0;
            end else begin
                case (state_q)
                    WAIT: begin
                        if (complete) begin
                            state_q <= EMIT;
                            seen    <= merged;
                            O       <= 1'b1;
                        end else if (abandon) begin
                            seen    <= '0;
                        end else begin
                            seen    <= merged;
                        end
                    end
                    EMIT: begin
                        state_q <= HOLD;
                        O       <= LEVEL;
                    end
                    HOLD: begin
                        O       <= LEVEL;
                    end
                    default: begin
                        state_q <= WAIT;
                        seen    <= '0;
                        O       <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_abro_n_fsm.sv
// tb/tb_abro_n_fsm.sv - directed and random bench for abro_n_fsm (pulse/N=2 and level/N=3 instances)
module tb_abro_n_fsm;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       r_restart = 1'b0;
    logic [1:0] in_a = '0;
    logic [2:0] in_b = '0;

    logic       a_o, b_o, a_to, b_to;
    logic [1:0] a_seen, a_state, b_state, a_fire;
    logic [2:0] b_seen;
    logic [7:0] b_fire;

    int errors = 0;
    int checks = 0;

    int nin[2]  = '{2, 3};
    int lvl[2]  = '{0, 1};
    int fmax[2] = '{3, 255};
    int m_seen[2], m_age[2], m_fire[2], m_hold[2];
    int m_to[2];

    abro_n_fsm #(.N_IN(2), .OUT_LEVEL(0), .CNT_W(2), .TIMEOUT_CYCLES(TO)) u_a (
        .clk(clk), .reset(reset), .r_restart(r_restart), .in_vec(in_a),
        .O(a_o), .seen(a_seen), .state(a_state), .fire_cnt(a_fire), .timeout(a_to)
    );

    abro_n_fsm #(.N_IN(3), .OUT_LEVEL(1), .CNT_W(8), .TIMEOUT_CYCLES(TO)) u_b (
        .clk(clk), .reset(reset), .r_restart(r_restart), .in_vec(in_b),
        .O(b_o), .seen(b_seen), .state(b_state), .fire_cnt(b_fire), .timeout(b_to)
    );

    always #5 clk = ~clk;

    // age: -1 while collecting, otherwise cycles elapsed since completion
    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_seen[k] = 0; m_age[k] = -1; m_fire[k] = 0; m_hold[k] = 0; m_to[k] = 0;
        end
    endfunction

    function automatic void model_step(int k, int vin, bit rr);
        int full = (1 << nin[k]) - 1;
        int u    = m_seen[k] | vin;
        m_to[k] = 0;
        if (rr) begin
            m_seen[k] = 0; m_age[k] = -1; m_hold[k] = 0;
        end else if (m_age[k] >= 0) begin
            if (m_age[k] < 1000) m_age[k]++;
        end else if (u == full) begin
            m_seen[k] = u; m_age[k] = 0; m_hold[k] = 0;
            if (m_fire[k] < fmax[k]) m_fire[k]++;
        end
`ifdef ABRO_TIMEOUT_EN
        else if (m_seen[k] != 0 && m_hold[k] == TO) begin
            m_seen[k] = 0; m_hold[k] = 0; m_to[k] = 1;
        end
`endif
        else begin
            m_hold[k] = (m_seen[k] != 0) ? m_hold[k] + 1 : 0;
            m_seen[k] = u;
        end
    endfunction

    function automatic int exp_state(int k);
        return (m_age[k] < 0) ? 0 : ((m_age[k] == 0) ? 1 : 2);
    endfunction

    function automatic int exp_o(int k);
        return ((m_age[k] == 0) || (lvl[k] != 0 && m_age[k] > 0)) ? 1 : 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("a_state", 32'(a_state), exp_state(0));
        check("a_o",     32'(a_o),     exp_o(0));
        check("a_seen",  32'(a_seen),  m_seen[0]);
        check("a_fire",  32'(a_fire),  m_fire[0]);
        check("a_to",    32'(a_to),    m_to[0]);
        check("b_state", 32'(b_state), exp_state(1));
        check("b_o",     32'(b_o),     exp_o(1));
        check("b_seen",  32'(b_seen),  m_seen[1]);
        check("b_fire",  32'(b_fire),  m_fire[1]);
        check("b_to",    32'(b_to),    m_to[1]);
    endtask

    task automatic cycle(input logic [1:0] a, input logic [2:0] b, input logic rr);
        in_a = a; in_b = b; r_restart = rr;
        @(posedge clk);
        model_step(0, int'(a), rr);
        model_step(1, int'(b), rr);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int sat_exp[5] = '{1, 2, 3, 3, 3};
        model_reset();
        #2;
        check_all();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_all();

        // pulse mode, bits arriving in separate cycles
        cycle(2'b01, 3'b000, 1'b0);
        check("a_seen_first", 32'(a_seen), 32'd1);
        cycle(2'b00, 3'b000, 1'b0);
        cycle(2'b00, 3'b000, 1'b0);
        cycle(2'b10, 3'b000, 1'b0);
        check("a_emit_o", 32'(a_o), 32'd1);
        check("a_emit_state", 32'(a_state), 32'd1);
        cycle(2'b00, 3'b000, 1'b0);
        check("a_hold_o", 32'(a_o), 32'd0);
        check("a_hold_state", 32'(a_state), 32'd2);
        cycle(2'b11, 3'b000, 1'b0);
        check("a_hold_ignore", 32'(a_o), 32'd0);
        check("a_fire_one", 32'(a_fire), 32'd1);
        cycle(2'b00, 3'b000, 1'b1);

        // level mode, all bits at once then restart
        cycle(2'b00, 3'b111, 1'b0);
        check("b_level_emit", 32'(b_o), 32'd1);
        for (int i = 0; i < 3; i++) cycle(2'b00, 3'b000, 1'b0);
        check("b_level_hold", 32'(b_o), 32'd1);
        cycle(2'b00, 3'b000, 1'b1);
        check("b_restart_o", 32'(b_o), 32'd0);
        check("b_restart_state", 32'(b_state), 32'd0);

        // restart beats completion
        cycle(2'b00, 3'b011, 1'b0);
        cycle(2'b00, 3'b100, 1'b1);
        check("b_beat_state", 32'(b_state), 32'd0);
        check("b_beat_seen", 32'(b_seen), 32'd0);
        check("b_beat_fire", 32'(b_fire), 32'd1);
        cycle(2'b00, 3'b100, 1'b0);
        check("b_beat_recollect", 32'(b_seen), 32'd4);

        // async reset in HOLD, checked before any clock edge
        cycle(2'b00, 3'b011, 1'b0);
        cycle(2'b00, 3'b000, 1'b0);
        check("b_pre_reset_state", 32'(b_state), 32'd2);
        #2;
        reset = 1'b0;
        #1;
        check("b_async_o", 32'(b_o), 32'd0);
        check("b_async_state", 32'(b_state), 32'd0);
        model_reset();
        check_all();
        #1;
        reset = 1'b1;
        @(negedge clk);
        check_all();

        // fire counter saturation at CNT_W=2
        for (int r = 0; r < 5; r++) begin
            cycle(2'b11, 3'b000, 1'b0);
            check("a_sat_fire", 32'(a_fire), sat_exp[r]);
            check("a_sat_emit", 32'(a_state), 32'd1);
            cycle(2'b00, 3'b000, 1'b1);
        end

`ifdef ABRO_TIMEOUT_EN
        cycle(2'b01, 3'b000, 1'b0);
        for (int i = 0; i < TO; i++) cycle(2'b00, 3'b000, 1'b0);
        cycle(2'b00, 3'b000, 1'b0);
        check("a_timeout_pulse", 32'(a_to), 32'd1);
        check("a_timeout_seen", 32'(a_seen), 32'd0);
        cycle(2'b00, 3'b000, 1'b0);
        check("a_timeout_end", 32'(a_to), 32'd0);
        cycle(2'b01, 3'b000, 1'b0);
        for (int i = 0; i < TO; i++) cycle(2'b00, 3'b000, 1'b0);
        cycle(2'b10, 3'b000, 1'b0);
        check("a_timeout_lost", 32'(a_to), 32'd0);
        check("a_timeout_emit", 32'(a_state), 32'd1);
        cycle(2'b00, 3'b000, 1'b1);
`endif

        for (int i = 0; i < 400; i++) begin
            cycle(2'($urandom & $urandom), 3'($urandom & $urandom), ($urandom_range(0, 9) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
